// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. One full-adder cell and a registered carry work
// through two WIDTH-bit operands LSB-first, one bit per clock, under a
// start/busy/done handshake. Subtraction is A + ~B + 1 with the borrow-in
// folded into the initial carry (carry = cin ^ sub).
//
// Parameters
//   WIDTH  operand/result width in bits, WIDTH >= 2 (default 8)
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, accepted in IDLE or DONE
//   sub    in   1      0 = a+b+cin, 1 = a-b-cin (sampled with start)
//   a      in   WIDTH  operand A (sampled with start)
//   b      in   WIDTH  operand B (sampled with start)
//   cin    in   1      carry-in / borrow-in (sampled with start)
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse; results valid from this cycle
//   sum    out  WIDTH  registered result
//   cout   out  1      carry out of MSB (sub mode: 1 = no borrow)
//   ovf    out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Full-adder cell on the current LSBs.
  logic bit_s;
  logic bit_c;
  logic last;
  logic [WIDTH-1:0] res_next;

  assign bit_s    = op_a[0] ^ op_b[0] ^ carry;
  assign bit_c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign last     = (cnt == LAST_BIT);
  assign res_next = {bit_s, res[WIDTH-1:1]};

  // NOTE: every register here is sequential state, so it is assigned with
  // non-blocking (<=) only; blocking assignments would make the shift chain
  // order-dependent in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all datapath registers are reset too, not just control; an
      // aborted operation must leave nothing behind for the next one.
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Inverting B and the carry turns the adder into A - B - cin.
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= bit_c;
          res   <= res_next;
          if (last) begin
            // carry still holds the carry into the MSB on this edge.
            sum   <= res_next;
            cout  <= bit_c;
            ovf   <= carry ^ bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder: an 8-bit instance driven from a vector
// table plus hand-written handshake/reset sequences, and a 4-bit instance
// swept exhaustively against a behavioural model.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // 4-bit instance
  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         poke;  // negedge index at which a stray start is injected, -1 = none
  } vec_t;

  // One 8-bit operation started from IDLE; checks latency, busy length,
  // pulse width and results.
  task automatic run8(input string nm, input vec_t v);
    int lat = -1;
    int busy_cnt = 0;
    logic overlap = 1'b0;
    @(negedge clk);
    a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; start8 = 1'b1;
    @(negedge clk);                       // load edge E0 has passed
    start8 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      start8 = 1'b0;
      if (busy8) busy_cnt++;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) begin
        lat = k;
        break;
      end
      if (k == v.poke) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = ~v.sub; start8 = 1'b1;
      end
    end
    check({nm, " done latency"}, lat, 8);
    check({nm, " busy cycles"}, busy_cnt, 8);
    check({nm, " busy&done"}, overlap, 0);
    check({nm, " sum"}, sum8, v.sum);
    check({nm, " cout"}, cout8, v.cout);
    check({nm, " ovf"}, ovf8, v.ovf);
    @(negedge clk);
    check({nm, " done width"}, done8, 0);
  endtask

  // One 4-bit operation compared against an arithmetic model.
  task automatic run4(input logic [3:0] ai, input logic [3:0] bi, input logic ci, input logic si);
    int lat = -1;
    logic [4:0] full;
    logic [3:0] es;
    logic       ec, eo;
    string      nm;
    if (!si) begin
      full = 5'(ai) + 5'(bi) + 5'(ci);
      es = full[3:0];
      ec = full[4];
      eo = (ai[3] == bi[3]) && (es[3] != ai[3]);
    end else begin
      es = ai - bi - 4'(ci);
      ec = (5'(ai) >= 5'(bi) + 5'(ci));
      eo = (ai[3] != bi[3]) && (es[3] != ai[3]);
    end
    nm = $sformatf("w4 a=%0h b=%0h cin=%0b sub=%0b", ai, bi, ci, si);
    @(negedge clk);
    a4 = ai; b4 = bi; cin4 = ci; sub4 = si; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (done4) begin
        lat = k;
        break;
      end
    end
    check({nm, " latency"}, lat, 4);
    check({nm, " sum"}, sum4, es);
    check({nm, " cout"}, cout4, ec);
    check({nm, " ovf"}, ovf4, eo);
  endtask

  vec_t vecs[11];

  initial begin
    int lat1, lat2;
    logic saw_done;

    vecs[0]  = '{8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1, -1};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, -1};
    vecs[2]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, -1};
    vecs[3]  = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, -1};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, -1};
    vecs[5]  = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, -1};
    vecs[6]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, -1};
    vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, -1};
    vecs[8]  = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, -1};
    vecs[9]  = '{8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1, 3};  // stray start in SHIFT
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, -1};

    // Reset state
    #2;
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset sum", sum8, 0);
    check("reset cout", cout8, 0);
    check("reset ovf", ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run8($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: start held high, second operands presented during SHIFT
    // (ignored there) and picked up at the DONE edge.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h55; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1;
    lat1 = -1;
    lat2 = -1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (done8 && lat1 < 0) begin
        lat1 = k;
        check("b2b first sum", sum8, 8'h91);
        check("b2b busy low in DONE", busy8, 0);
      end else if (done8) begin
        lat2 = k;
        start8 = 1'b0;
        break;
      end
      if (lat1 >= 0 && k == lat1 + 8)
        check("b2b first sum held", sum8, 8'h91);
    end
    check("b2b first latency", lat1, 8);
    check("b2b second spacing", lat2 - lat1, 9);
    check("b2b second sum", sum8, 8'hF0);
    check("b2b second cout", cout8, 0);
    @(negedge clk);
    check("b2b done width", done8, 0);
    check("b2b idle", busy8, 0);

    // Reset mid-operation, asserted between clock edges.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", busy8, 0);
    check("midreset done", done8, 0);
    check("midreset sum", sum8, 0);
    check("midreset cout", cout8, 0);
    check("midreset ovf", ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("midreset no done/busy", saw_done, 0);
    check("midreset sum stays 0", sum8, 0);
    run8("after reset", '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, -1});

    // Exhaustive 4-bit sweep.
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          for (int si = 0; si < 2; si++)
            run4(4'(ai), 4'(bi), 1'(ci), 1'(si));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a registered carry. It adds or subtracts two WIDTH-bit operands LSB-first, one bit per clock, under a start/busy/done handshake. It is the sequential, width-generic successor to the lab's combinational full adder, for datapaths that trade latency for area.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range WIDTH >= 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- sub  in  1  mode, sampled with start: 0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in).
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in (add) or borrow-in (sub), sampled with start.
- busy  out  1  high while the state is SHIFT.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- sum  out  WIDTH  registered result.
- cout  out  1  carry out of the MSB; in sub mode 1 = no borrow.
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, SHIFT, DONE; reset state IDLE.
- Load (accepted start):
  - opA <= a; opB <= b ^ {WIDTH{sub}}; carry <= cin ^ sub; cnt <= 0.
  - Clear the internal shift register; go to SHIFT.
- SHIFT, each edge:
  - s = opA[0]^opB[0]^carry; carry <= majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1; s is shifted into the MSB of the internal result register.
  - cnt increments.
  - On the edge where cnt == WIDTH-1:
    - sum <= final result register value;
    - cout <= final carry;
    - ovf <= carry-into-MSB ^ final carry (carry-into-MSB is the carry register value while bit WIDTH-1 is processed);
    - go to DONE.
- DONE: done = 1 for exactly one cycle.
  - With start high: load immediately (back-to-back), go to SHIFT.
  - Otherwise: go to IDLE.
- start in SHIFT is ignored; a, b, sub and cin are don't-care outside the load edge.
- sum, cout and ovf change only on the completion edge and hold until the next completion or reset.
- cnt width is $clog2(WIDTH); wraps only via load, never free-runs.
- Arithmetic is modulo 2^WIDTH. In sub mode, cout = 1 iff A >= B + cin as unsigned values.

## Timing
- Reset (rst_n low, asynchronous, any state):
  - state IDLE; busy = 0; done = 0; sum = 0; cout = 0; ovf = 0.
  - Internal registers cleared.
  - An in-flight operation is discarded: no done pulse, and outputs are not updated.
- Reset release takes effect at the next edge; start on the first edge with rst_n high is accepted.
- Latency: start accepted at edge E0.
  - busy is high from E0 through edge E0+WIDTH.
  - The completion edge is E0+WIDTH: results update and done rises.
  - done falls at E0+WIDTH+1.
- Throughput with start held high: one result every WIDTH+1 cycles; busy drops for exactly the DONE cycle.
- done and busy are never high together.
- All outputs come directly from registers, with no combinational path from inputs.

## Test plan
- WIDTH=8 add, a=0x3C b=0x55 cin=0 sub=0 -> sum=0x91, cout=0, ovf=1; done pulses at exactly start edge + 8, one cycle wide; busy high for 8 cycles.
- WIDTH=8 carry wrap, a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF b=0x00 cin=1 -> sum=0x00, cout=1, ovf=0.
- WIDTH=8 subtract:
  - a=0x10 b=0x20 cin=0 sub=1 -> sum=0xF0, cout=0, ovf=0.
  - a=0x80 b=0x01 sub=1 -> sum=0x7F, cout=1, ovf=1.
  - a=0x05 b=0x05 cin=1 sub=1 -> sum=0xFF, cout=0.
- Handshake:
  - A start pulse during SHIFT (with different operands) is ignored; the result matches the first operands.
  - start held high is accepted in DONE; the second result appears 9 cycles after the first done.
- Reset mid-operation: drop rst_n asynchronously (between edges) 4 cycles into an operation.
  - Required: all outputs go to 0 immediately; no done pulse.
  - A subsequent 0x01+0x02 returns sum=0x03 on schedule.
- WIDTH=4 exhaustive, all a, b, cin, sub, compared against a behavioural model: sum, cout and ovf all match; every done lands at start edge + 4.
